// File: rtl/x_oddr_ser.sv
// x_oddr_ser: parallel-to-DDR serializer feeding ODDR D1/D2/CE, LSB pair first.
// Optional X_ODDR_SER_UFLOW_EN adds sticky UFLOW and saturating UFLOW_CNT outputs.
module x_oddr_ser #(
   parameter int   WIDTH = 8,
   parameter logic IDLE  = 1'b0
) (
   input  logic             C,
   input  logic             RN,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DVALID,
   output logic             DREADY,
   output logic             D1,
   output logic             D2,
   output logic             CE,
   output logic             BUSY
`ifdef X_ODDR_SER_UFLOW_EN
   ,
   output logic             UFLOW,
   output logic [7:0]       UFLOW_CNT
`endif
);
   localparam int CW = $clog2(WIDTH / 2 + 1);
   localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d1_q, d1_d, d2_q, d2_d, ce_q, ce_d;
   logic             idle_cnt, acc;
   assign idle_cnt = cnt_q == '0;
   assign DREADY   = idle_cnt || (cnt_q == CW'(1));
   assign acc      = DVALID && DREADY;
   assign D1       = d1_q;
   assign D2       = d2_q;
   assign CE       = ce_q;
   assign BUSY     = !idle_cnt || ce_q;
   // With one pair left, the old pair goes out while the new word loads whole.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      d1_d  = IDLE;
      d2_d  = IDLE;
      ce_d  = 1'b0;
      if (acc && idle_cnt) begin
         d1_d  = DIN[0];
         d2_d  = DIN[1];
         ce_d  = 1'b1;
         sr_d  = DIN >> 2;
         cnt_d = HALF - CW'(1);
      end else if (!idle_cnt) begin
         d1_d  = sr_q[0];
         d2_d  = sr_q[1];
         ce_d  = 1'b1;
         sr_d  = acc ? DIN : sr_q >> 2;
         cnt_d = acc ? HALF : cnt_q - CW'(1);
      end
   end
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         sr_q  <= '0;
         cnt_q <= '0;
         d1_q  <= IDLE;
         d2_q  <= IDLE;
         ce_q  <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         d1_q  <= d1_d;
         d2_q  <= d2_d;
         ce_q  <= ce_d;
      end
   end
`ifdef X_ODDR_SER_UFLOW_EN
   logic       uflow_q, uflow_d, ev;
   logic [7:0] ucnt_q, ucnt_d;
   assign ev        = ce_q && idle_cnt && !acc;
   assign uflow_d   = uflow_q || ev;
   assign ucnt_d    = (ev && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
   assign UFLOW     = uflow_q;
   assign UFLOW_CNT = ucnt_q;
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         uflow_q <= 1'b0;
         ucnt_q  <= '0;
      end else begin
         uflow_q <= uflow_d;
         ucnt_q  <= ucnt_d;
      end
   end
`endif
endmodule
